// File: rtl/mag_cook_ctrl.sv
// Magnetron cook-cycle controller: BCD MM:SS countdown at 1 s resolution,
// door interlock, pause/resume, cancel and end-of-cook beep timing.
module mag_cook_ctrl #(
  parameter int TICK_CYC = 50_000_000,
  parameter int DONE_CYC = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] time_in,
  input  logic        load,
  input  logic        start,
  input  logic        stop_clear,
  input  logic        door_closed,
  output logic        mag_set,
  output logic        mag_reset,
  output logic [15:0] time_left,
  output logic [2:0]  state,
  output logic        load_err,
  output logic        done_beep
);

  localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int DW = (DONE_CYC > 0) ? $clog2(DONE_CYC + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOADED  = 3'd1,
    S_COOKING = 3'd2,
    S_PAUSED  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t        state_q;
  logic [15:0]   time_left_q;
  logic [PW-1:0] pre_q;
  logic [DW-1:0] beep_cnt_q;
  logic          done_beep_q;
  logic          load_err_q;
  logic          mag_set_q;
  logic          mag_reset_q;

  logic          tick;
  logic          load_ok;
  logic [15:0]   time_dec;

  // Every digit a legal BCD value, seconds tens at most 5, and not 00:00.
  function automatic logic bcd_valid(input logic [15:0] t);
    return (t[15:12] <= 4'd9) && (t[11:8] <= 4'd9) &&
           (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9) && (t != 16'h0000);
  endfunction

  // One-second BCD decrement with borrow chain; only used on values above 00:01.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (r[3:0] != 4'd0) begin
      r[3:0] = r[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (r[7:4] != 4'd0) begin
        r[7:4] = r[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (r[11:8] != 4'd0) begin
          r[11:8] = r[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = r[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign tick     = (pre_q == PRE_LAST);
  assign load_ok  = bcd_valid(time_in);
  assign time_dec = bcd_dec(time_left_q);

  assign state     = state_q;
  assign time_left = time_left_q;
  assign mag_set   = mag_set_q;
  assign mag_reset = mag_reset_q;
  assign load_err  = load_err_q;
  assign done_beep = done_beep_q;

  // State machine, countdown, prescaler and registered magnetron drive.
  // The magnetron is driven on exactly the edges whose next state is COOKING;
  // any pause freezes the prescaler so a resumed cook keeps its partial second.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      time_left_q <= 16'h0000;
      pre_q       <= '0;
      beep_cnt_q  <= '0;
      done_beep_q <= 1'b0;
      load_err_q  <= 1'b0;
      mag_set_q   <= 1'b0;
      mag_reset_q <= 1'b1;
    end else begin
      load_err_q  <= 1'b0;
      mag_set_q   <= 1'b0;
      mag_reset_q <= 1'b1;
      case (state_q)
        S_IDLE, S_LOADED, S_PAUSED: begin
          if (stop_clear) begin
            state_q     <= S_IDLE;
            time_left_q <= 16'h0000;
          end else if (load) begin
            if (load_ok) begin
              state_q     <= S_LOADED;
              time_left_q <= time_in;
              pre_q       <= '0;
            end else begin
              load_err_q <= 1'b1;
            end
          end else if (start && door_closed && (state_q != S_IDLE)) begin
            state_q     <= S_COOKING;
            mag_set_q   <= 1'b1;
            mag_reset_q <= 1'b0;
            if (state_q == S_LOADED) pre_q <= '0;
          end
        end
        S_COOKING: begin
          if (!door_closed || stop_clear) begin
            state_q <= S_PAUSED;
          end else if (tick) begin
            pre_q <= '0;
            if (time_left_q <= 16'h0001) begin
              state_q     <= S_DONE;
              time_left_q <= 16'h0000;
              done_beep_q <= (DONE_CYC > 0);
              beep_cnt_q  <= DW'(DONE_CYC);
            end else begin
              time_left_q <= time_dec;
              mag_set_q   <= 1'b1;
              mag_reset_q <= 1'b0;
            end
          end else begin
            pre_q       <= pre_q + 1'b1;
            mag_set_q   <= 1'b1;
            mag_reset_q <= 1'b0;
          end
        end
        S_DONE: begin
          if (!door_closed || stop_clear) begin
            state_q     <= S_IDLE;
            time_left_q <= 16'h0000;
            done_beep_q <= 1'b0;
            beep_cnt_q  <= '0;
          end else if (tick) begin
            pre_q <= '0;
            if (beep_cnt_q != '0) begin
              beep_cnt_q <= beep_cnt_q - 1'b1;
              if (beep_cnt_q == DW'(1)) done_beep_q <= 1'b0;
            end
          end else begin
            pre_q <= pre_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mag_cook_ctrl.sv
// Bench for mag_cook_ctrl: seconds-based behavioural model compared every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_mag_cook_ctrl;
  localparam int TICK = 4;
  localparam int DCYC = 3;

  logic        clk;
  logic        reset_n;
  logic [15:0] time_in;
  logic        load, start, stop_clear, door_closed;
  logic        mag_set, mag_reset, load_err, done_beep;
  logic [15:0] time_left;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  mag_cook_ctrl #(.TICK_CYC(TICK), .DONE_CYC(DCYC)) dut (
    .clk(clk), .reset_n(reset_n), .time_in(time_in), .load(load),
    .start(start), .stop_clear(stop_clear), .door_closed(door_closed),
    .mag_set(mag_set), .mag_reset(mag_reset), .time_left(time_left),
    .state(state), .load_err(load_err), .done_beep(done_beep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: remaining time in whole seconds, prescaler phase, beep ticks.
  int m_state, m_secs, m_ph, m_dticks;
  bit m_beep, m_err, m_valid;

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return 16'(((mm / 10) << 12) | ((mm % 10) << 8) | ((ss / 10) << 4) | (ss % 10));
  endfunction

  function automatic bit tin_valid(input logic [15:0] t);
    int d3, d2, d1, d0;
    d3 = int'(t) / 4096;
    d2 = (int'(t) / 256) % 16;
    d1 = (int'(t) / 16) % 16;
    d0 = int'(t) % 16;
    return d3 <= 9 && d2 <= 9 && d1 <= 5 && d0 <= 9 && int'(t) != 0;
  endfunction

  function automatic int tin_secs(input logic [15:0] t);
    int d3, d2, d1, d0;
    d3 = int'(t) / 4096;
    d2 = (int'(t) / 256) % 16;
    d1 = (int'(t) / 16) % 16;
    d0 = int'(t) % 16;
    return (d3 * 10 + d2) * 60 + d1 * 10 + d0;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_state = 0; m_secs = 0; m_ph = 0; m_beep = 0; m_err = 0; m_dticks = 0;
      m_valid = 1;
    end else if (m_valid) begin
      m_err = 0;
      case (m_state)
        0, 1, 3: begin
          if (stop_clear) begin
            m_state = 0; m_secs = 0;
          end else if (load) begin
            if (tin_valid(time_in)) begin
              m_state = 1; m_secs = tin_secs(time_in); m_ph = 0;
            end else m_err = 1;
          end else if (start && door_closed && m_state != 0) begin
            if (m_state == 1) m_ph = 0;
            m_state = 2;
          end
        end
        2: begin
          if (!door_closed || stop_clear) m_state = 3;
          else if (m_ph == TICK - 1) begin
            m_ph = 0;
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
              m_state = 4; m_beep = 1; m_dticks = 0;
            end
          end else m_ph = m_ph + 1;
        end
        4: begin
          if (!door_closed || stop_clear) begin
            m_state = 0; m_beep = 0; m_secs = 0;
          end else if (m_ph == TICK - 1) begin
            m_ph = 0;
            if (m_beep) begin
              m_dticks = m_dticks + 1;
              if (m_dticks == DCYC) m_beep = 0;
            end
          end else m_ph = m_ph + 1;
        end
        default: m_state = 0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare DUT against the model on every cycle once reset has been seen.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("state", 16'(state), 16'(m_state));
      chk("time_left", time_left, to_bcd(m_secs));
      chk("mag_set", 16'(mag_set), 16'(m_state == 2));
      chk("mag_reset", 16'(mag_reset), 16'(m_state != 2));
      chk("load_err", 16'(load_err), 16'(m_err));
      chk("done_beep", 16'(done_beep), 16'(m_beep));
    end
  end

  task automatic step(input logic l, input logic s, input logic sc);
    @(negedge clk);
    load = l; start = s; stop_clear = sc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  logic [15:0] bad [3];
  int secs_r;

  initial begin
    reset_n = 0; door_closed = 1; load = 0; start = 0; stop_clear = 0; time_in = 0;
    bad[0] = 16'h0070; bad[1] = 16'h00A0; bad[2] = 16'h0000;
    idle(2);
    reset_n = 1;
    chk("rst_state", 16'(state), 16'h0);
    chk("rst_tl", time_left, 16'h0000);
    chk("rst_magrst", 16'(mag_reset), 16'h1);
    chk("rst_magset", 16'(mag_set), 16'h0);

    // Reset in the middle of a cook.
    time_in = 16'h0005;
    step(1, 0, 0); step(0, 1, 0); idle(2);
    chk("mid_cook_state", 16'(state), 16'h2);
    reset_n = 0; idle(1); reset_n = 1;
    chk("midrst_state", 16'(state), 16'h0);
    chk("midrst_tl", time_left, 16'h0000);
    chk("midrst_magset", 16'(mag_set), 16'h0);
    chk("midrst_magrst", 16'(mag_reset), 16'h1);

    // Normal cook of 3 s and the done beep window.
    time_in = 16'h0003;
    step(1, 0, 0); step(0, 1, 0); idle(1);
    chk("cook_state", 16'(state), 16'h2);
    chk("cook_magset", 16'(mag_set), 16'h1);
    chk("cook_tl3", time_left, 16'h0003);
    idle(4); chk("cook_tl2", time_left, 16'h0002);
    idle(4); chk("cook_tl1", time_left, 16'h0001);
    idle(4);
    chk("done_tl", time_left, 16'h0000);
    chk("done_state", 16'(state), 16'h4);
    chk("done_magset", 16'(mag_set), 16'h0);
    chk("done_beep_on", 16'(done_beep), 16'h1);
    idle(11); chk("beep_last", 16'(done_beep), 16'h1);
    idle(1); chk("beep_off", 16'(done_beep), 16'h0);
    step(0, 0, 1); idle(1);
    chk("done_clear", 16'(state), 16'h0);

    // BCD borrow chains.
    time_in = 16'h1000;
    step(1, 0, 0); step(0, 1, 0); idle(5);
    chk("borrow_1000", time_left, 16'h0959);
    step(0, 0, 1);
    time_in = 16'h0100;
    step(1, 0, 0); step(0, 1, 0); idle(5);
    chk("borrow_0100", time_left, 16'h0059);
    step(0, 0, 1); step(0, 0, 1); idle(1);

    // Door interlock with retained partial second.
    time_in = 16'h0031;
    step(1, 0, 0); step(0, 1, 0); idle(5);
    chk("door_tl30", time_left, 16'h0030);
    idle(2);
    door_closed = 0; idle(1);
    chk("door_paused", 16'(state), 16'h3);
    chk("door_magset", 16'(mag_set), 16'h0);
    step(0, 1, 0); idle(1);
    chk("door_open_start", 16'(state), 16'h3);
    door_closed = 1; idle(1);
    step(0, 1, 0); idle(1);
    chk("resume_state", 16'(state), 16'h2);
    idle(1); chk("resume_tl_hold", time_left, 16'h0030);
    idle(1); chk("resume_tl29", time_left, 16'h0029);
    step(0, 0, 1); step(0, 0, 1); idle(1);

    // Rejected loads.
    for (int i = 0; i < 3; i++) begin
      time_in = bad[i];
      step(1, 0, 0); idle(1);
      chk("bad_load_err", 16'(load_err), 16'h1);
      chk("bad_load_state", 16'(state), 16'h0);
      idle(1);
      chk("bad_load_pulse", 16'(load_err), 16'h0);
    end

    // stop_clear beats start; clear from PAUSED; start ignored in IDLE.
    time_in = 16'h0005;
    step(1, 0, 0); step(0, 1, 0); idle(2);
    step(0, 1, 1); idle(1);
    chk("prio_paused", 16'(state), 16'h3);
    step(0, 0, 1); idle(1);
    chk("clear_idle", 16'(state), 16'h0);
    chk("clear_tl", time_left, 16'h0000);
    step(0, 1, 0); idle(1);
    chk("idle_start", 16'(state), 16'h0);

    // Randomized traffic.
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      reset_n = ($urandom_range(0, 699) != 0);
      if ($urandom_range(0, 39) == 0) door_closed = ~door_closed;
      load = ($urandom_range(0, 9) == 0);
      start = ($urandom_range(0, 5) == 0);
      stop_clear = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 3))
        0, 1: begin
          secs_r = int'($urandom_range(1, 20));
          time_in = to_bcd(secs_r);
        end
        2: time_in = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                      4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
        default: time_in = 16'($urandom);
      endcase
    end
    @(negedge clk);
    reset_n = 1; load = 0; start = 0; stop_clear = 0;
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
